// File: rtl/aib_link_status_rx.sv
// AIB link status receiver: synchronizes far-side status bumps and runs the link bring-up FSM.
// Optional sideband check is compiled in with `define AIB_LINK_SR_CHECK_EN.
module aib_link_status_rx (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_fs_adapter_rstn,
  input  logic       i_fs_mac_rdy,
  input  logic       i_fs_sr_data,
  input  logic       i_fs_sr_load,
  input  logic       c_link_en,
  input  logic [7:0] c_debounce_cnt,
  input  logic       c_drop_cnt_clr,
  output logic       o_fs_adapter_rstn_sync,
  output logic       o_fs_mac_rdy_sync,
  output logic [1:0] o_link_state,
  output logic       o_link_up,
  output logic       o_link_drop,
  output logic [7:0] o_drop_count
);

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_WAIT_RSTN = 2'd1,
    ST_WAIT_RDY  = 2'd2,
    ST_UP        = 2'd3
  } link_state_e;

  // Synchronizer bit order: adapter_rstn, mac_rdy, sr_data, sr_load.
  logic [3:0]  meta_q, meta_d, sync_q, sync_d;
  link_state_e state_q, state_d;
  logic [7:0]  dbc_q, dbc_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic        link_up_q, link_up_d;
  logic        link_drop_q, link_drop_d;

  logic rstn_s;
  logic rdy_s;
  logic sr_ok;
  logic rdy_cond;
  logic link_ok;

  assign rstn_s = sync_q[0];
  assign rdy_s  = sync_q[1];

`ifdef AIB_LINK_SR_CHECK_EN
  assign sr_ok = sync_q[2] & sync_q[3];
`else
  logic unused_sr;
  assign sr_ok     = 1'b1;
  assign unused_sr = ^sync_q[3:2];
`endif

  assign rdy_cond = rdy_s & sr_ok;
  assign link_ok  = rstn_s & rdy_cond;

  always_comb begin
    meta_d = {i_fs_sr_load, i_fs_sr_data, i_fs_mac_rdy, i_fs_adapter_rstn};
    sync_d = meta_q;
  end

  // Disable overrides everything; the debounce counter restarts on any state change.
  always_comb begin
    state_d      = state_q;
    dbc_d        = dbc_q;
    link_drop_d  = 1'b0;
    drop_count_d = drop_count_q;
    if (!c_link_en) begin
      state_d = ST_DISABLED;
      dbc_d   = '0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_WAIT_RSTN;
          dbc_d   = '0;
        end
        ST_WAIT_RSTN: begin
          if (!rstn_s) begin
            dbc_d = '0;
          end else if (dbc_q == c_debounce_cnt) begin
            state_d = ST_WAIT_RDY;
            dbc_d   = '0;
          end else begin
            dbc_d = dbc_q + 8'd1;
          end
        end
        ST_WAIT_RDY: begin
          if (!rstn_s) begin
            state_d = ST_WAIT_RSTN;
            dbc_d   = '0;
          end else if (!rdy_cond) begin
            dbc_d = '0;
          end else if (dbc_q == c_debounce_cnt) begin
            state_d = ST_UP;
            dbc_d   = '0;
          end else begin
            dbc_d = dbc_q + 8'd1;
          end
        end
        ST_UP: begin
          dbc_d = '0;
          if (!link_ok) begin
            state_d     = ST_WAIT_RSTN;
            link_drop_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
              drop_count_d = drop_count_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = ST_DISABLED;
          dbc_d   = '0;
        end
      endcase
    end
    if (c_drop_cnt_clr) begin
      drop_count_d = '0;
    end
    link_up_d = (state_d == ST_UP);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      meta_q       <= '0;
      sync_q       <= '0;
      state_q      <= ST_DISABLED;
      dbc_q        <= '0;
      drop_count_q <= '0;
      link_up_q    <= 1'b0;
      link_drop_q  <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      state_q      <= state_d;
      dbc_q        <= dbc_d;
      drop_count_q <= drop_count_d;
      link_up_q    <= link_up_d;
      link_drop_q  <= link_drop_d;
    end
  end

  assign o_fs_adapter_rstn_sync = sync_q[0];
  assign o_fs_mac_rdy_sync      = sync_q[1];
  assign o_link_state           = state_q;
  assign o_link_up              = link_up_q;
  assign o_link_drop            = link_drop_q;
  assign o_drop_count           = drop_count_q;

endmodule
